// File: rtl/meas_disp_sched.sv
// Round-robin scheduler + binary-to-BCD formatter for the VPP/FREQ/PERIOD/VOLT overlay fields.
// Results are staged in shadows and committed on frame_start; define LZ_BLANK_EN for leading-zero blanking.
module meas_disp_sched #(
    parameter int VAL_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [3:0]         req,
    input  logic [4*VAL_W-1:0] val_bus,
    output logic [3:0]         ack,
    output logic [63:0]        disp_bcd,
    output logic [15:0]        disp_blank,
    output logic               busy,
    output logic [3:0]         pending
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_CONV  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam int                CNT_W   = $clog2(VAL_W);
    localparam logic [CNT_W-1:0]  LAST_IT = CNT_W'(VAL_W - 1);

    logic [1:0]       state;
    logic [1:0]       rr_ptr;
    logic [1:0]       grant;
    logic [1:0]       grant_nxt;
    logic [1:0]       idx;
    logic             found;
    logic [CNT_W-1:0] cnt;
    logic [VAL_W-1:0] bin;
    logic [15:0]      bcd;
    logic [15:0]      shadow [4];

    function automatic logic [VAL_W-1:0] sat_val(input logic [VAL_W-1:0] v);
        if (32'(v) > 32'(MAX_VAL))
            return VAL_W'(MAX_VAL);
        return v;
    endfunction

    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++)
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    // First requester at or after rr_ptr, wrapping 3 -> 0.
    always_comb begin
        grant_nxt = rr_ptr;
        found     = 1'b0;
        idx       = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && req[idx]) begin
                grant_nxt = idx;
                found     = 1'b1;
            end
        end
    end

    assign ack  = (state == S_LOAD) ? (4'b0001 << grant) : 4'b0000;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rr_ptr <= 2'd0;
            grant  <= 2'd0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant <= grant_nxt;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt    <= '0;
                    rr_ptr <= grant + 2'd1;
                    state  <= S_CONV;
                end
                S_CONV: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_IT)
                        state <= S_WRITE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Conversion datapath: only meaningful between LOAD and WRITE, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            bin <= sat_val(val_bus[grant*VAL_W +: VAL_W]);
            bcd <= '0;
        end else if (state == S_CONV) begin
            {bcd, bin} <= {bcd_adjust(bcd), bin} << 1;
        end
    end

`ifdef LZ_BLANK_EN
    function automatic logic [3:0] blank_mask(input logic [15:0] d);
        logic [3:0] m;
        m[3] = (d[15:12] == 4'd0);
        m[2] = m[3] && (d[11:8] == 4'd0);
        m[1] = m[2] && (d[7:4] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction
`endif

    // A WRITE on a channel overrides a coincident commit of that channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 4; ch++)
                shadow[ch] <= '0;
            pending  <= '0;
            disp_bcd <= '0;
`ifdef LZ_BLANK_EN
            disp_blank <= 16'hEEEE;
`endif
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                if (state == S_WRITE && grant == 2'(ch)) begin
                    shadow[ch]  <= bcd;
                    pending[ch] <= 1'b1;
                end else if (frame_start && pending[ch]) begin
                    disp_bcd[ch*16 +: 16] <= shadow[ch];
                    pending[ch]           <= 1'b0;
`ifdef LZ_BLANK_EN
                    disp_blank[ch*4 +: 4] <= blank_mask(shadow[ch]);
`endif
                end
            end
        end
    end

`ifndef LZ_BLANK_EN
    assign disp_blank = 16'h0000;
`endif

endmodule

// File: tb/tb_meas_disp_sched.sv
// Scoreboard bench for meas_disp_sched: expected grants/digits queued at stimulus, checked at ack and commit.
module tb_meas_disp_sched;

    localparam int VAL_W = 14;
`ifdef LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    localparam logic [15:0] RST_BLANK = LZ ? 16'hEEEE : 16'h0000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frame_start;
    logic [3:0]         req;
    logic [4*VAL_W-1:0] val_bus;
    logic [3:0]         ack;
    logic [63:0]        disp_bcd;
    logic [15:0]        disp_blank;
    logic               busy;
    logic [3:0]         pending;

    meas_disp_sched #(.VAL_W(VAL_W), .MAX_VAL(9999)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .req(req),
        .val_bus(val_bus), .ack(ack), .disp_bcd(disp_bcd),
        .disp_blank(disp_blank), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        int          val;
        logic [15:0] bcd;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_disp [4];
    logic [3:0]  a;
    int          n;

    function automatic int clampv(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] model_bcd(input int v);
        int c;
        c = clampv(v);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [3:0] model_blank(input int v);
        int c;
        c = clampv(v);
        if (!LZ) return 4'b0000;
        if (c < 10) return 4'b1110;
        if (c < 100) return 4'b1100;
        if (c < 1000) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_val(input int ch, input int v);
        val_bus[ch*VAL_W +: VAL_W] = VAL_W'(v);
    endtask

    task automatic push_exp(input int ch, input int v);
        exp_t x;
        x.ch  = ch;
        x.val = v;
        x.bcd = model_bcd(v);
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req         = '0;
        frame_start = 1'b0;
        val_bus     = '0;
        for (int i = 0; i < 4; i++) exp_disp[i] = '0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_ack(output logic [3:0] got, output int cyc);
        cyc = 0;
        got = ack;
        while (got == 4'b0 && cyc < 40) begin
            tick();
            cyc++;
            got = ack;
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 40) begin
            tick();
            c++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout busy=%b required=0", busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (ack !== 4'b0)        begin failures++; $display("FAIL rst_ack got=%h exp=0", ack); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (pending !== 4'b0)    begin failures++; $display("FAIL rst_pending got=%h exp=0", pending); end
        if (disp_bcd !== 64'b0)  begin failures++; $display("FAIL rst_disp got=%h exp=0", disp_bcd); end
        if (disp_blank !== RST_BLANK) begin failures++; $display("FAIL rst_blank got=%h exp=%h", disp_blank, RST_BLANK); end
    endtask

    task automatic test_single();
        set_val(0, 1234);
        push_exp(0, 1234);
        req = 4'b0001;
        tick();
        e = sb.pop_front();
        checks += 2;
        if (ack !== 4'(1 << e.ch)) begin failures++; $display("FAIL single_ack got=%b exp=%b", ack, 4'(1 << e.ch)); end
        if (busy !== 1'b1)         begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        req = 4'b0000;
        repeat (15) tick();
        checks++;
        if (pending !== 4'b0000) begin failures++; $display("FAIL single_pending_early got=%b exp=0000", pending); end
        tick();
        checks++;
        if (pending !== 4'b0001) begin failures++; $display("FAIL single_pending got=%b exp=0001", pending); end
        frame();
        exp_disp[0] = e.bcd;
        checks += 3;
        if (disp_bcd[15:0] !== e.bcd) begin failures++; $display("FAIL single_disp got=%h exp=%h", disp_bcd[15:0], e.bcd); end
        if (disp_blank[3:0] !== model_blank(e.val)) begin failures++; $display("FAIL single_blank got=%b exp=%b", disp_blank[3:0], model_blank(e.val)); end
        if (pending !== 4'b0000) begin failures++; $display("FAIL single_commit_pending got=%b exp=0000", pending); end
    endtask

    task automatic test_round_robin();
        int vals [4];
        vals = '{1, 22, 333, 4444};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_val(i, vals[i]);
            push_exp(i, vals[i]);
        end
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            wait_ack(a, n);
            if (k > 0) n++;
            e = sb.pop_front();
            checks += 2;
            if (a !== 4'(1 << e.ch)) begin failures++; $display("FAIL rr_order k=%0d got=%b exp=%b", k, a, 4'(1 << e.ch)); end
            if (n !== ((k == 0) ? 1 : 17)) begin failures++; $display("FAIL rr_spacing k=%0d got=%0d exp=%0d", k, n, (k == 0) ? 1 : 17); end
            exp_disp[e.ch] = e.bcd;
            req = req & ~a;
        end
        wait_idle();
        frame();
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (disp_bcd[i*16 +: 16] !== exp_disp[i]) begin failures++; $display("FAIL rr_disp ch=%0d got=%h exp=%h", i, disp_bcd[i*16 +: 16], exp_disp[i]); end
            if (disp_blank[i*4 +: 4] !== model_blank(vals[i])) begin failures++; $display("FAIL rr_blank ch=%0d got=%b exp=%b", i, disp_blank[i*4 +: 4], model_blank(vals[i])); end
        end
    endtask

    task automatic test_boundary();
        int vals [4];
        vals = '{16383, 10000, 9999, 0};
        for (int k = 0; k < 4; k++) begin
            set_val(2, vals[k]);
            push_exp(2, vals[k]);
            req = 4'b0100;
            wait_ack(a, n);
            req = 4'b0000;
            e = sb.pop_front();
            checks++;
            if (a !== 4'(1 << e.ch)) begin failures++; $display("FAIL bnd_ack v=%0d got=%b exp=%b", vals[k], a, 4'(1 << e.ch)); end
            wait_idle();
            frame();
            exp_disp[2] = e.bcd;
            checks += 2;
            if (disp_bcd[47:32] !== e.bcd) begin failures++; $display("FAIL bnd_disp v=%0d got=%h exp=%h", vals[k], disp_bcd[47:32], e.bcd); end
            if (disp_blank[11:8] !== model_blank(vals[k])) begin failures++; $display("FAIL bnd_blank v=%0d got=%b exp=%b", vals[k], disp_blank[11:8], model_blank(vals[k])); end
        end
    endtask

    task automatic test_frame_collision();
        logic [15:0] bcd3;
        set_val(3, 77);
        push_exp(3, 77);
        req = 4'b1000;
        wait_ack(a, n);
        req = 4'b0000;
        e = sb.pop_front();
        bcd3 = e.bcd;
        checks++;
        if (a !== 4'(1 << e.ch)) begin failures++; $display("FAIL coll_ack3 got=%b exp=%b", a, 4'(1 << e.ch)); end
        wait_idle();
        set_val(1, 555);
        push_exp(1, 555);
        req = 4'b0010;
        wait_ack(a, n);
        req = 4'b0000;
        e = sb.pop_front();
        checks++;
        if (a !== 4'(1 << e.ch)) begin failures++; $display("FAIL coll_ack1 got=%b exp=%b", a, 4'(1 << e.ch)); end
        repeat (15) tick();
        frame();
        exp_disp[3] = bcd3;
        checks += 3;
        if (disp_bcd[31:16] !== exp_disp[1]) begin failures++; $display("FAIL coll_hold got=%h exp=%h", disp_bcd[31:16], exp_disp[1]); end
        if (pending !== 4'b0010) begin failures++; $display("FAIL coll_pending got=%b exp=0010", pending); end
        if (disp_bcd[63:48] !== exp_disp[3]) begin failures++; $display("FAIL coll_other got=%h exp=%h", disp_bcd[63:48], exp_disp[3]); end
        frame();
        exp_disp[1] = e.bcd;
        checks += 2;
        if (disp_bcd[31:16] !== exp_disp[1]) begin failures++; $display("FAIL coll_deferred got=%h exp=%h", disp_bcd[31:16], exp_disp[1]); end
        if (pending !== 4'b0000) begin failures++; $display("FAIL coll_pending2 got=%b exp=0000", pending); end
    endtask

    task automatic test_starvation();
        set_val(0, 5);
        set_val(3, 9);
        push_exp(0, 5);
        req = 4'b0001;
        wait_ack(a, n);
        e = sb.pop_front();
        checks++;
        if (a !== 4'(1 << e.ch)) begin failures++; $display("FAIL starve_ack0 got=%b exp=%b", a, 4'(1 << e.ch)); end
        req = 4'b1001;
        push_exp(3, 9);
        tick();
        wait_ack(a, n);
        n++;
        e = sb.pop_front();
        exp_disp[3] = e.bcd;
        checks += 2;
        if (a !== 4'(1 << e.ch)) begin failures++; $display("FAIL starve_ack3 got=%b exp=%b", a, 4'(1 << e.ch)); end
        if (n > 17) begin failures++; $display("FAIL starve_latency got=%0d exp<=17", n); end
        req = 4'b0001;
        push_exp(0, 5);
        tick();
        wait_ack(a, n);
        req = 4'b0000;
        e = sb.pop_front();
        exp_disp[0] = e.bcd;
        checks++;
        if (a !== 4'(1 << e.ch)) begin failures++; $display("FAIL starve_ack0b got=%b exp=%b", a, 4'(1 << e.ch)); end
        wait_idle();
        frame();
        checks += 2;
        if (disp_bcd[63:48] !== exp_disp[3]) begin failures++; $display("FAIL starve_disp3 got=%h exp=%h", disp_bcd[63:48], exp_disp[3]); end
        if (disp_bcd[15:0] !== exp_disp[0]) begin failures++; $display("FAIL starve_disp0 got=%h exp=%h", disp_bcd[15:0], exp_disp[0]); end
    endtask

    task automatic test_reset_midconv();
        logic [3:0] seen_ack;
        logic [3:0] seen_pend;
        set_val(2, 4321);
        push_exp(2, 4321);
        req = 4'b0100;
        wait_ack(a, n);
        req = 4'b0000;
        e = sb.pop_front();
        checks++;
        if (a !== 4'(1 << e.ch)) begin failures++; $display("FAIL mid_ack got=%b exp=%b", a, 4'(1 << e.ch)); end
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #2;
        checks += 5;
        if (ack !== 4'b0)       begin failures++; $display("FAIL mid_rst_ack got=%b exp=0", ack); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        if (pending !== 4'b0)   begin failures++; $display("FAIL mid_rst_pending got=%b exp=0", pending); end
        if (disp_bcd !== 64'b0) begin failures++; $display("FAIL mid_rst_disp got=%h exp=0", disp_bcd); end
        if (disp_blank !== RST_BLANK) begin failures++; $display("FAIL mid_rst_blank got=%h exp=%h", disp_blank, RST_BLANK); end
        rst_n = 1'b1;
        seen_ack  = '0;
        seen_pend = '0;
        repeat (20) begin
            tick();
            seen_ack  = seen_ack | ack;
            seen_pend = seen_pend | pending;
        end
        checks += 2;
        if (seen_ack !== 4'b0)  begin failures++; $display("FAIL mid_post_ack got=%b exp=0", seen_ack); end
        if (seen_pend !== 4'b0) begin failures++; $display("FAIL mid_post_pending got=%b exp=0", seen_pend); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_boundary();
        test_frame_collision();
        test_starvation();
        test_reset_midconv();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
